// File: rtl/tea_cipher_core_if.sv
// Request/result bus of tea_cipher_core: valid/ready request side and valid/ready result side.
// Purely structural, no latency of its own.
// The alg select line exists only when TEA_XTEA_EN is defined.
interface tea_cipher_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [127:0] key;
  logic [63:0]  din;
`ifdef TEA_XTEA_EN
  logic         alg;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  dout;
  logic         busy;

`ifdef TEA_XTEA_EN
  modport master (
    output in_valid, mode, key, din, alg, out_ready,
    input  in_ready, out_valid, dout, busy
  );
  modport slave (
    input  in_valid, mode, key, din, alg, out_ready,
    output in_ready, out_valid, dout, busy
  );
`else
  modport master (
    output in_valid, mode, key, din, out_ready,
    input  in_ready, out_valid, dout, busy
  );
  modport slave (
    input  in_valid, mode, key, din, out_ready,
    output in_ready, out_valid, dout, busy
  );
`endif
endinterface

// File: rtl/tea_cipher_core.sv
// TEA encrypt/decrypt engine (XTEA rounds added when TEA_XTEA_EN is defined), runtime key/mode.
// Latency: ROUNDS/RPC cycles from the accept edge to out_valid.
// Backpressure: one request in flight; in_ready low until the held result is taken by out_ready.
module tea_cipher_core #(
  parameter int unsigned ROUNDS = 32,            // TEA cycles, >= 1
  parameter int unsigned RPC    = 1,             // rounds per clock: 1, 2 or 4, divides ROUNDS
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input logic              clk,
  input logic              reset,
  tea_cipher_core_if.slave bus
);

  localparam int unsigned   CW       = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0] RPC_C    = CW'(RPC);
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
  // Decrypt starts from the sum encryption ends with: DELTA*ROUNDS mod 2^32.
  localparam logic [63:0]   SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0]   SUM_DEC  = SUM_PROD[31:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] sum;
  } blk_t;

  state_e        state_q, state_d;
  blk_t          blk_q, blk_d;
  logic [127:0]  key_q, key_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   dout_q, dout_d;
`ifdef TEA_XTEA_EN
  logic          alg_q, alg_d;
`endif

  blk_t round_out;
  logic last_run;
  logic in_ready_c;
  logic busy_c;
  logic out_valid_c;

  function automatic logic [31:0] tea_mix(input logic [31:0] v, input logic [31:0] s,
                                          input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // One TEA round; decrypt undoes the encrypt steps in reverse order.
  function automatic blk_t tea_round(input blk_t b, input logic [127:0] k, input logic dec);
    blk_t r;
    r = b;
    if (!dec) begin
      r.sum = b.sum + DELTA;
      r.v0  = b.v0 + tea_mix(b.v1, r.sum, k[127:96], k[95:64]);
      r.v1  = b.v1 + tea_mix(r.v0, r.sum, k[63:32], k[31:0]);
    end else begin
      r.v1  = b.v1 - tea_mix(b.v0, b.sum, k[63:32], k[31:0]);
      r.v0  = b.v0 - tea_mix(r.v1, b.sum, k[127:96], k[95:64]);
      r.sum = b.sum - DELTA;
    end
    return r;
  endfunction

`ifdef TEA_XTEA_EN
  // Key word select; index 0 is the most significant word.
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    unique case (idx)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [31:0] xtea_mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  // One XTEA cycle; the sum update sits between the two half-rounds.
  function automatic blk_t xtea_round(input blk_t b, input logic [127:0] k, input logic dec);
    blk_t r;
    r = b;
    if (!dec) begin
      r.v0  = b.v0 + (xtea_mix(b.v1) ^ (b.sum + key_word(k, b.sum[1:0])));
      r.sum = b.sum + DELTA;
      r.v1  = b.v1 + (xtea_mix(r.v0) ^ (r.sum + key_word(k, r.sum[12:11])));
    end else begin
      r.v1  = b.v1 - (xtea_mix(b.v0) ^ (b.sum + key_word(k, b.sum[12:11])));
      r.sum = b.sum - DELTA;
      r.v0  = b.v0 - (xtea_mix(r.v1) ^ (r.sum + key_word(k, r.sum[1:0])));
    end
    return r;
  endfunction
`endif

  // Chain RPC rounds combinationally from the registered block state.
  always_comb begin
    round_out = blk_q;
    for (int unsigned i = 0; i < RPC; i++) begin
`ifdef TEA_XTEA_EN
      round_out = alg_q ? xtea_round(round_out, key_q, mode_q)
                        : tea_round(round_out, key_q, mode_q);
`else
      round_out = tea_round(round_out, key_q, mode_q);
`endif
    end
  end

  // Counter never wraps: the final RUN cycle is the one that lands exactly on ROUNDS.
  assign last_run = ((cnt_q + RPC_C) == ROUNDS_C);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (last_run) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded purely from the current state.
  always_comb begin
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready_c  = 1'b1;
      S_RUN:   busy_c      = 1'b1;
      S_DONE:  out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture the request on accept, advance rounds in RUN, freeze the result on the last one.
  always_comb begin
    blk_d  = blk_q;
    key_d  = key_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
`ifdef TEA_XTEA_EN
    alg_d  = alg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          key_d     = bus.key;
          mode_d    = bus.mode;
          blk_d.v0  = bus.din[63:32];
          blk_d.v1  = bus.din[31:0];
          blk_d.sum = bus.mode ? SUM_DEC : 32'd0;
          cnt_d     = '0;
`ifdef TEA_XTEA_EN
          alg_d     = bus.alg;
`endif
        end
      end
      S_RUN: begin
        blk_d = round_out;
        cnt_d = cnt_q + RPC_C;
        if (last_run) dout_d = {round_out.v0, round_out.v1};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q  <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      dout_q <= '0;
`ifdef TEA_XTEA_EN
      alg_q  <= 1'b0;
`endif
    end else begin
      blk_q  <= blk_d;
      key_q  <= key_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
`ifdef TEA_XTEA_EN
      alg_q  <= alg_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.dout      = dout_q;

endmodule
